conv_sequencer: RTL and testbench
=================================

// Module: conv_sequencer
// PURPOSE
//  Sequences the convolution datapath for one job at a time.
//  - Loads an NxN kernel and an NxN pixel window from an 8-bit valid/ready byte stream.
//  - Packs both into the 200-bit, 25-lane, row-major (stride 5) operand format the datapath expects.
//  - Waits for the datapath to settle, captures the 16-bit signed result and holds it until the host acks.
//  - Sits between the coprocessor host interface and the convolution unit.
// PARAMETERS
//  WAIT_CYCLES  1  datapath settle cycles spent in COMPUTE before capture; legal range 1..15
// PORTS
//  clk          in   1    single system clock, rising edge
//  rst_n        in   1    asynchronous reset, active-low
//  start        in   1    job request; accepted only in IDLE
//  size         in   2    matrix size: 00=2x2, 01=3x3, 10=4x4, 11=5x5; sampled with start
//  abort        in   1    synchronous cancel; wins over every other input
//  in_valid     in   1    byte stream valid
//  in_data      in   8    byte stream data; kernel bytes are signed, pixel bytes unsigned
//  in_ready     out  1    byte stream ready
//  busy         out  1    high in every state except IDLE
//  conv_pixel   out  200  packed pixel operand to the datapath
//  conv_kernel  out  200  packed kernel operand to the datapath
//  conv_size    out  2    latched size to the datapath
//  conv_result  in   200  datapath result; bits [15:0] are used, the rest are ignored
//  res_valid    out  1    result valid; held until res_ack
//  res_data     out  16   captured result, signed
//  res_ack      in   1    host consumes the result
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; all outputs 0, including both operand registers and conv_size.
//  - FSM states: IDLE, LOAD_K, LOAD_P, COMPUTE, DONE.
//  - IDLE, start=1:
//    - Latch size; N = size+2; element counter k=0.
//    - Clear all 25 lanes of the pixel register.
//    - Go to LOAD_K, which also clears all 25 kernel lanes.
//  - LOAD_K / LOAD_P:
//    - in_ready=1; a transfer happens on in_valid & in_ready.
//    - Element k goes to row r=k/N, col c=k%N, lane r*5+c, bits [(r*5+c)*8 +: 8].
//    - Lanes outside NxN stay 0.
//    - After N*N transfers, LOAD_K goes to LOAD_P and LOAD_P goes to COMPUTE; k resets to 0 on each transition.
//    - in_valid gaps stall the load with no timeout.
//  - COMPUTE:
//    - in_ready=0; hold operands stable for WAIT_CYCLES cycles.
//    - On the last cycle, res_data <= conv_result[15:0].
//    - Next state is DONE.
//  - DONE:
//    - res_valid=1; res_data is stable.
//    - res_ack=1 moves to IDLE; res_valid=0 from the next cycle.
//    - start in the same cycle as res_ack is ignored.
//  - Latency: res_valid rises exactly WAIT_CYCLES+1 cycles after the clock edge that accepts the final pixel byte.
//  - start outside IDLE: ignored; size is not re-latched.
//  - res_ack outside DONE: ignored.
//  - abort=1 in any state: IDLE next cycle; res_valid=0; in_ready=0.
//    - Operand registers are left unchanged until the next start.
//    - Partially accepted bytes are discarded.
//  - Async reset mid-load or mid-result: immediate return to the reset values above; no partial result is ever presented.
//  - Element count: 4/9/16/25 bytes per phase. The counter is 5 bits and never wraps past N*N-1.
// CONFIGURATION
//  - CONV_SEQ_KERNEL_REUSE_EN defined:
//    - Adds input port keep_kernel (1 bit), sampled with start, and an internal kernel_loaded flag.
//    - kernel_loaded is set on LOAD_K completion.
//    - kernel_loaded is cleared by reset, by abort, and by any start whose size differs from the latched size.
//    - Start with keep_kernel=1 and kernel_loaded=1: skip LOAD_K, go straight to LOAD_P, reuse the existing kernel register.
//    - Otherwise behaviour is as without the macro.
//  - CONV_SEQ_KERNEL_REUSE_EN undefined: no keep_kernel port and no flag; every job loads the kernel.
// TESTING
//  1. size=00, kernel bytes 1,1,1,1, pixels 10,20,30,40.
//     -> Kernel lanes 0,1,5,6 = 1, all other lanes 0.
//     -> res_data=100, res_valid exactly WAIT_CYCLES+1 cycles after the last pixel.
//  2. size=01, kernel all 0x01, pixels all 20 (sum 180 > 128).
//     -> res_data=255 (0x00FF).
//     Then size=01, kernel all 0xFF (-1), pixels all 1 -> res_data=0xFFF7 (-9).
//  3. size=11, 50 bytes with in_valid low on every other cycle.
//     -> Exactly 50 transfers, in_ready low in COMPUTE/DONE, correct packed lanes 0..24.
//     -> Result held across 5 cycles of res_ack=0; IDLE the cycle after res_ack.
//  4. abort pulsed after 3 kernel bytes of a 3x3 job, then a new 2x2 job.
//     -> IDLE next cycle, res_valid never rises for the aborted job.
//     -> The second job returns its correct sum.
//  5. rst_n pulsed low during LOAD_P.
//     -> All outputs 0 immediately; start with no reset de-assert glitch; the next job completes normally.
//  6. (CONV_SEQ_KERNEL_REUSE_EN) Job A 2x2, then job B with keep_kernel=1 and 4 pixel bytes only.
//     -> Correct result for job B using A's kernel.
//     Then keep_kernel=1 with size=01 -> full kernel load is required.

Source files
------------

// File: rtl/conv_sequencer_if.sv
// Host/datapath bundle for conv_sequencer: job control, byte stream, operands and result.
// keep_kernel exists only when CONV_SEQ_KERNEL_REUSE_EN is defined.
interface conv_sequencer_if;
   logic         start;
   logic [1:0]   size;
   logic         abort;
   logic         in_valid;
   logic [7:0]   in_data;
   logic         in_ready;
   logic         busy;
   logic [199:0] conv_pixel;
   logic [199:0] conv_kernel;
   logic [1:0]   conv_size;
   logic [199:0] conv_result;
   logic         res_valid;
   logic [15:0]  res_data;
   logic         res_ack;
`ifdef CONV_SEQ_KERNEL_REUSE_EN
   logic         keep_kernel;

   modport master (
      output start, size, abort, in_valid, in_data, conv_result, res_ack, keep_kernel,
      input  in_ready, busy, conv_pixel, conv_kernel, conv_size, res_valid, res_data
   );
   modport slave (
      input  start, size, abort, in_valid, in_data, conv_result, res_ack, keep_kernel,
      output in_ready, busy, conv_pixel, conv_kernel, conv_size, res_valid, res_data
   );
`else
   modport master (
      output start, size, abort, in_valid, in_data, conv_result, res_ack,
      input  in_ready, busy, conv_pixel, conv_kernel, conv_size, res_valid, res_data
   );
   modport slave (
      input  start, size, abort, in_valid, in_data, conv_result, res_ack,
      output in_ready, busy, conv_pixel, conv_kernel, conv_size, res_valid, res_data
   );
`endif
endinterface

// File: rtl/conv_sequencer.sv
// Loads an NxN kernel and pixel window from a byte stream into 25-lane operands, then captures the datapath result.
// Latency: res_valid rises WAIT_CYCLES+1 cycles after the final pixel byte; held until res_ack.
// Backpressure: in_ready only in the load states; kernel reuse under CONV_SEQ_KERNEL_REUSE_EN.
module conv_sequencer #(
   parameter int WAIT_CYCLES = 1
) (
   input logic             clk,
   input logic             rst_n,
   conv_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD_K, LOAD_P, COMPUTE, DONE} state_t;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   state_t       state;
   state_t       state_nxt;
   logic [1:0]   size_q;
   logic [2:0]   row;
   logic [2:0]   col;
   logic [3:0]   wait_cnt;
   logic [199:0] ker_q;
   logic [199:0] pix_q;
   logic [15:0]  res_q;
   logic         in_ready_c;
   logic         busy_c;
   logic         res_valid_c;
   logic         xfer;
   logic         last_elem;
   logic         last_wait;
   logic         skip_k;
   logic [2:0]   n_m1;
   logic [4:0]   lane;
   logic         unused_res_bits;

   assign n_m1      = {1'b0, size_q} + 3'd1;
   assign lane      = {2'b00, row} * 5'd5 + {2'b00, col};
   assign xfer      = bus.in_valid & in_ready_c;
   assign last_elem = (row == n_m1) && (col == n_m1);
   assign last_wait = (wait_cnt == WAIT_LAST);
   assign unused_res_bits = ^bus.conv_result[199:16];

`ifdef CONV_SEQ_KERNEL_REUSE_EN
   logic kernel_loaded;

   // A size change invalidates the stored kernel, so reuse also requires a matching size.
   assign skip_k = bus.keep_kernel & kernel_loaded & (bus.size == size_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kernel_loaded <= 1'b0;
      end else if (bus.abort) begin
         kernel_loaded <= 1'b0;
      end else if (state == IDLE && bus.start && bus.size != size_q) begin
         kernel_loaded <= 1'b0;
      end else if (state == LOAD_K && xfer && last_elem) begin
         kernel_loaded <= 1'b1;
      end
   end
`else
   assign skip_k = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = skip_k ? LOAD_P : LOAD_K;
         LOAD_K:  if (xfer && last_elem) state_nxt = LOAD_P;
         LOAD_P:  if (xfer && last_elem) state_nxt = COMPUTE;
         COMPUTE: if (last_wait) state_nxt = DONE;
         DONE:    if (bus.res_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.abort) state_nxt = IDLE;
   end

   always_comb begin
      in_ready_c  = (state == LOAD_K) || (state == LOAD_P);
      busy_c      = (state != IDLE);
      res_valid_c = (state == DONE);
   end

   // COMPUTE spends one launch cycle plus WAIT_CYCLES settle cycles before capturing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         size_q   <= 2'd0;
         row      <= 3'd0;
         col      <= 3'd0;
         wait_cnt <= 4'd0;
         ker_q    <= '0;
         pix_q    <= '0;
         res_q    <= 16'd0;
      end else if (bus.abort) begin
         row <= 3'd0;
         col <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  size_q <= bus.size;
                  row    <= 3'd0;
                  col    <= 3'd0;
                  pix_q  <= '0;
                  if (!skip_k) ker_q <= '0;
               end
            end
            LOAD_K, LOAD_P: begin
               if (xfer) begin
                  if (state == LOAD_K) ker_q[{lane, 3'b000} +: 8] <= bus.in_data;
                  else                 pix_q[{lane, 3'b000} +: 8] <= bus.in_data;
                  if (last_elem) begin
                     row      <= 3'd0;
                     col      <= 3'd0;
                     wait_cnt <= 4'd0;
                  end else if (col == n_m1) begin
                     col <= 3'd0;
                     row <= row + 3'd1;
                  end else begin
                     col <= col + 3'd1;
                  end
               end
            end
            COMPUTE: begin
               wait_cnt <= wait_cnt + 4'd1;
               if (last_wait) res_q <= bus.conv_result[15:0];
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.busy        = busy_c;
   assign bus.res_valid   = res_valid_c;
   assign bus.res_data    = res_q;
   assign bus.conv_size   = size_q;
   assign bus.conv_kernel = ker_q;
   assign bus.conv_pixel  = pix_q;
endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer with a transaction-level model and a datapath stand-in.
module tb_conv_sequencer;
   localparam int W = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   dut_xfers = 0;

   logic [7:0] kbuf [25];
   logic [7:0] pbuf [25];

   // Model state: phase 0 idle, 1 kernel load, 2 pixel load, 3 compute, 4 result held.
   int           m_phase;
   int           m_k;
   int           m_n;
   int           m_wait;
   logic [1:0]   m_size;
   logic [199:0] m_ker;
   logic [199:0] m_pix;
   logic [15:0]  m_res;
`ifdef CONV_SEQ_KERNEL_REUSE_EN
   bit           m_kl;
`endif

   conv_sequencer_if bus ();

   conv_sequencer #(.WAIT_CYCLES(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Datapath stand-in: signed kernel times unsigned pixel, positive sums above 128 saturate to 0x00FF.
   function automatic logic [15:0] dp(input logic [199:0] kv, input logic [199:0] pv);
      int s = 0;
      for (int l = 0; l < 25; l++)
         s += int'($signed(kv[l*8 +: 8])) * int'(pv[l*8 +: 8]);
      return (s > 128) ? 16'h00FF : 16'(s);
   endfunction

   assign bus.conv_result = {184'd0, dp(bus.conv_kernel, bus.conv_pixel)};

   task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_step();
      int lane;
      bit reuse;
      reuse = 1'b0;
      if (!rst_n) begin
         m_phase = 0; m_k = 0; m_n = 2; m_wait = 0; m_size = 2'd0;
         m_ker = '0; m_pix = '0; m_res = 16'd0;
`ifdef CONV_SEQ_KERNEL_REUSE_EN
         m_kl = 1'b0;
`endif
      end else begin
         if (bus.in_valid && bus.in_ready) dut_xfers++;
         if (bus.abort) begin
            m_phase = 0;
            m_k     = 0;
`ifdef CONV_SEQ_KERNEL_REUSE_EN
            m_kl    = 1'b0;
`endif
         end else begin
            case (m_phase)
               0: if (bus.start) begin
`ifdef CONV_SEQ_KERNEL_REUSE_EN
                     reuse = bus.keep_kernel && m_kl && (bus.size == m_size);
                     if (bus.size != m_size) m_kl = 1'b0;
`endif
                     m_size = bus.size;
                     m_n    = int'(bus.size) + 2;
                     m_k    = 0;
                     m_pix  = '0;
                     if (reuse) m_phase = 2;
                     else begin
                        m_ker   = '0;
                        m_phase = 1;
                     end
                  end
               1, 2: if (bus.in_valid) begin
                     lane = (m_k / m_n) * 5 + (m_k % m_n);
                     if (m_phase == 1) m_ker[lane*8 +: 8] = bus.in_data;
                     else              m_pix[lane*8 +: 8] = bus.in_data;
                     m_k++;
                     if (m_k == m_n * m_n) begin
                        m_k = 0;
                        if (m_phase == 1) begin
                           m_phase = 2;
`ifdef CONV_SEQ_KERNEL_REUSE_EN
                           m_kl = 1'b1;
`endif
                        end else begin
                           m_phase = 3;
                           m_wait  = 0;
                           m_res   = dp(m_ker, m_pix);
                        end
                     end
                  end
               3: begin
                     m_wait++;
                     if (m_wait == W + 1) m_phase = 4;
                  end
               4: if (bus.res_ack) m_phase = 0;
               default: m_phase = 0;
            endcase
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      chk("cyc_in_ready",  200'(bus.in_ready),  200'(m_phase == 1 || m_phase == 2));
      chk("cyc_busy",      200'(bus.busy),      200'(m_phase != 0));
      chk("cyc_res_valid", 200'(bus.res_valid), 200'(m_phase == 4));
      chk("cyc_conv_size", 200'(bus.conv_size), 200'(m_size));
      chk("cyc_kernel",    bus.conv_kernel,     m_ker);
      chk("cyc_pixel",     bus.conv_pixel,      m_pix);
      if (m_phase == 4) chk("cyc_res_data", 200'(bus.res_data), 200'(m_res));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [1:0] sz, input bit keep);
      bus.start = 1'b1;
      bus.size  = sz;
`ifdef CONV_SEQ_KERNEL_REUSE_EN
      bus.keep_kernel = keep;
`endif
      tick();
      bus.start = 1'b0;
`ifdef CONV_SEQ_KERNEL_REUSE_EN
      bus.keep_kernel = 1'b0;
`endif
   endtask

   task automatic send(input logic [7:0] b, input bit gap);
      int t  = 0;
      bit ok = 1'b0;
      if (gap) tick();
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!ok && t < 64) begin
         ok = bus.in_ready;
         tick();
         t++;
      end
      bus.in_valid = 1'b0;
      chk("send_accepted", 200'(ok), 200'(1));
   endtask

   task automatic job_load(input logic [1:0] sz, input bit keep, input bit load_k, input bit gap);
      int n = (int'(sz) + 2) * (int'(sz) + 2);
      start_job(sz, keep);
      if (load_k) for (int i = 0; i < n; i++) send(kbuf[i], gap);
      for (int i = 0; i < n; i++) send(pbuf[i], gap);
   endtask

   task automatic job_finish(input logic [15:0] exp, input int hold, input string tag);
      for (int i = 0; i <= W; i++) begin
         chk({tag, "_early_valid"}, 200'(bus.res_valid), 200'(0));
         chk({tag, "_compute_rdy"}, 200'(bus.in_ready), 200'(0));
         tick();
      end
      chk({tag, "_valid"}, 200'(bus.res_valid), 200'(1));
      chk({tag, "_res"},   200'(bus.res_data),  200'(exp));
      for (int h = 0; h < hold; h++) begin
         tick();
         chk({tag, "_hold_valid"}, 200'(bus.res_valid), 200'(1));
         chk({tag, "_hold_res"},   200'(bus.res_data),  200'(exp));
         chk({tag, "_hold_rdy"},   200'(bus.in_ready),  200'(0));
      end
      bus.res_ack = 1'b1;
      bus.start   = 1'b1;
      tick();
      bus.res_ack = 1'b0;
      bus.start   = 1'b0;
      chk({tag, "_ack_valid"}, 200'(bus.res_valid), 200'(0));
      chk({tag, "_ack_busy"},  200'(bus.busy),      200'(0));
   endtask

   initial begin
      logic [199:0] exp_k;
      logic [199:0] exp_p;
      bus.start = 1'b0; bus.size = 2'd0; bus.abort = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.res_ack = 1'b0;
`ifdef CONV_SEQ_KERNEL_REUSE_EN
      bus.keep_kernel = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",      200'(bus.busy),      200'(0));
      chk("rst_in_ready",  200'(bus.in_ready),  200'(0));
      chk("rst_res_valid", 200'(bus.res_valid), 200'(0));
      chk("rst_res_data",  200'(bus.res_data),  200'(0));
      chk("rst_kernel",    bus.conv_kernel,     200'(0));
      chk("rst_pixel",     bus.conv_pixel,      200'(0));
      rst_n = 1'b1;
      tick();

      // 2x2 sum, lane placement and exact latency.
      kbuf[0:3] = '{8'd1, 8'd1, 8'd1, 8'd1};
      pbuf[0:3] = '{8'd10, 8'd20, 8'd30, 8'd40};
      job_load(2'd0, 1'b0, 1'b1, 1'b0);
      exp_k = '0; exp_k[7:0] = 8'd1; exp_k[15:8] = 8'd1; exp_k[47:40] = 8'd1; exp_k[55:48] = 8'd1;
      exp_p = '0; exp_p[7:0] = 8'd10; exp_p[15:8] = 8'd20; exp_p[47:40] = 8'd30; exp_p[55:48] = 8'd40;
      chk("t1_kernel_lanes", bus.conv_kernel, exp_k);
      chk("t1_pixel_lanes",  bus.conv_pixel,  exp_p);
      job_finish(16'd100, 0, "t1");

      // 3x3 saturating and negative results.
      for (int i = 0; i < 9; i++) begin kbuf[i] = 8'h01; pbuf[i] = 8'd20; end
      job_load(2'd1, 1'b0, 1'b1, 1'b0);
      chk("t2_conv_size", 200'(bus.conv_size), 200'(1));
      job_finish(16'h00FF, 0, "t2a");
      for (int i = 0; i < 9; i++) begin kbuf[i] = 8'hFF; pbuf[i] = 8'd1; end
      job_load(2'd1, 1'b0, 1'b1, 1'b0);
      job_finish(16'hFFF7, 0, "t2b");

      // 5x5 with in_valid gaps, result held without ack.
      for (int i = 0; i < 25; i++) begin
         kbuf[i] = (i % 2 == 0) ? 8'h01 : 8'hFF;
         pbuf[i] = 8'(i);
      end
      dut_xfers = 0;
      job_load(2'd3, 1'b0, 1'b1, 1'b1);
      chk("t3_xfers", 200'(dut_xfers), 200'(50));
      job_finish(16'd12, 5, "t3");

      // Abort mid-kernel, then a fresh 2x2 job.
      start_job(2'd1, 1'b0);
      for (int i = 0; i < 3; i++) send(8'd7, 1'b0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("t4_abort_busy",  200'(bus.busy),      200'(0));
      chk("t4_abort_rdy",   200'(bus.in_ready),  200'(0));
      for (int i = 0; i < 4; i++) begin
         chk("t4_abort_valid", 200'(bus.res_valid), 200'(0));
         tick();
      end
      kbuf[0:3] = '{8'd2, 8'd3, 8'hFF, 8'd1};
      pbuf[0:3] = '{8'd5, 8'd6, 8'd7, 8'd8};
      job_load(2'd0, 1'b0, 1'b1, 1'b0);
      job_finish(16'd29, 0, "t4");

      // Async reset in the middle of the pixel load.
      for (int i = 0; i < 9; i++) begin kbuf[i] = 8'd3; pbuf[i] = 8'd4; end
      start_job(2'd1, 1'b0);
      for (int i = 0; i < 9; i++) send(kbuf[i], 1'b0);
      for (int i = 0; i < 2; i++) send(pbuf[i], 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy",      200'(bus.busy),      200'(0));
      chk("t5_in_ready",  200'(bus.in_ready),  200'(0));
      chk("t5_res_valid", 200'(bus.res_valid), 200'(0));
      chk("t5_res_data",  200'(bus.res_data),  200'(0));
      chk("t5_conv_size", 200'(bus.conv_size), 200'(0));
      chk("t5_kernel",    bus.conv_kernel,     200'(0));
      chk("t5_pixel",     bus.conv_pixel,      200'(0));
      tick();
      rst_n = 1'b1;
      tick();
      kbuf[0:3] = '{8'd1, 8'd2, 8'd3, 8'd4};
      pbuf[0:3] = '{8'd1, 8'd1, 8'd1, 8'd1};
      job_load(2'd0, 1'b0, 1'b1, 1'b0);
      job_finish(16'd10, 0, "t5");

`ifdef CONV_SEQ_KERNEL_REUSE_EN
      // Kernel reuse for same size, full reload when size changes.
      kbuf[0:3] = '{8'd3, 8'd0, 8'd0, 8'd1};
      pbuf[0:3] = '{8'd4, 8'd0, 8'd0, 8'd5};
      job_load(2'd0, 1'b0, 1'b1, 1'b0);
      job_finish(16'd17, 0, "t6a");
      pbuf[0:3] = '{8'd1, 8'd2, 8'd3, 8'd4};
      job_load(2'd0, 1'b1, 1'b0, 1'b0);
      job_finish(16'd7, 0, "t6b");
      for (int i = 0; i < 9; i++) begin kbuf[i] = 8'd1; pbuf[i] = 8'd2; end
      job_load(2'd1, 1'b1, 1'b1, 1'b0);
      job_finish(16'd18, 0, "t6c");
`endif

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, expected test completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
